// File: rtl/fade_pkg.sv
// fade_pkg: shared types and defaults for the fade ramp generator.
// Mode encoding, ramp FSM states and the state entered on a mode change.
package fade_pkg;

  localparam int FADE_WIDTH   = 8;
  localparam int FADE_RATE_W  = 4;
  localparam int FADE_DWELL_W = 4;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_SAW      = 2'b01,
    MODE_TRI      = 2'b10,
    MODE_FADE_OUT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISE,
    ST_DWELL_HI,
    ST_FALL,
    ST_DWELL_LO,
    ST_DONE
  } state_e;

  function automatic state_e entry_state(
    input mode_e m,
    input logic  lvl_zero
  );
    state_e s;
    s = ST_IDLE;
    unique case (m)
      MODE_HOLD:     s = ST_IDLE;
      MODE_SAW:      s = ST_RISE;
      MODE_TRI:      s = ST_RISE;
      MODE_FADE_OUT: s = lvl_zero ? ST_DONE : ST_FALL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fade_prescaler.sv
// fade_prescaler: step tick every 2^rate enabled clocks.
// Restarts from zero on a rate change or an external restart request.
module fade_prescaler
  import fade_pkg::*;
#(
  parameter int RATE_W = FADE_RATE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ena,
  input  logic              i_restart,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_tick
);

  localparam int CNT_W = (1 << RATE_W) - 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [RATE_W-1:0] r_rate_q;
  logic [CNT_W:0]    w_span;
  logic [CNT_W-1:0]  w_term;
  logic              w_chg;

  assign w_span = {{CNT_W{1'b0}}, 1'b1} << i_rate;
  assign w_term = w_span[CNT_W-1:0] - CNT_W'(1);
  assign w_chg  = i_restart || (i_rate != r_rate_q);
  assign o_tick = i_ena && !w_chg && (r_cnt == w_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rate_q <= '0;
    end else if (i_ena) begin
      r_rate_q <= i_rate;
      if (w_chg || o_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fade_ramp_gen.sv
// fade_ramp_gen: hold/saw/triangle/fade-out level source for the PWM fader.
// The level steps on prescaled ticks; duty_out reloads only at PWM period ends.
module fade_ramp_gen
  import fade_pkg::*;
#(
  parameter int WIDTH   = FADE_WIDTH,
  parameter int RATE_W  = FADE_RATE_W,
  parameter int DWELL_W = FADE_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         mode,
  input  logic [RATE_W-1:0]  rate,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [WIDTH-1:0]   level_in,
  input  logic               pwm_period_done,
  output logic [WIDTH-1:0]   duty_out,
  output logic               duty_upd,
  output logic               at_peak,
  output logic               at_floor
);

  localparam logic [WIDTH-1:0]   LMAX = '1;
  localparam logic [WIDTH-1:0]   LONE = WIDTH'(1);
  localparam logic [WIDTH-1:0]   LPRE = LMAX - LONE;
  localparam logic [DWELL_W-1:0] DONE = DWELL_W'(1);

  mode_e              w_mode;
  logic               w_mode_chg;
  logic               w_tick;
  state_e             r_state;
  mode_e              r_mode_q;
  logic               r_mode_vld;
  logic [WIDTH-1:0]   r_level;
  logic [WIDTH-1:0]   r_duty;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_upd;

  assign w_mode     = mode_e'(mode);
  // First enabled cycle after reset counts as a mode change.
  assign w_mode_chg = !r_mode_vld || (w_mode != r_mode_q);

  fade_prescaler #(
    .RATE_W(RATE_W)
  ) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ena    (ena),
    .i_restart(w_mode_chg),
    .i_rate   (rate),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode_q   <= MODE_HOLD;
      r_mode_vld <= 1'b0;
      r_level    <= '0;
      r_dwell    <= '0;
      r_duty     <= '0;
      r_upd      <= 1'b0;
    end else begin
      r_upd <= ena && pwm_period_done;
      if (ena) begin
        r_mode_q   <= w_mode;
        r_mode_vld <= 1'b1;
        if (pwm_period_done)
          r_duty <= r_level;
        if (w_mode_chg) begin
          r_state <= entry_state(w_mode, r_level == '0);
        end else if (w_mode == MODE_HOLD) begin
          r_level <= level_in;
        end else if (w_tick) begin
          unique case (r_state)
            ST_RISE: begin
              if (w_mode == MODE_SAW) begin
                r_level <= r_level + LONE;
              end else begin
                if (r_level != LMAX)
                  r_level <= r_level + LONE;
                if (r_level >= LPRE) begin
                  r_state <= ST_DWELL_HI;
                  r_dwell <= dwell;
                end
              end
            end
            ST_DWELL_HI: begin
              if (r_dwell == '0) begin
                r_state <= ST_FALL;
                r_level <= r_level - LONE;
              end else begin
                r_dwell <= r_dwell - DONE;
              end
            end
            ST_FALL: begin
              if (r_level <= LONE) begin
                r_level <= '0;
                r_dwell <= dwell;
                r_state <= (w_mode == MODE_FADE_OUT) ? ST_DONE : ST_DWELL_LO;
              end else begin
                r_level <= r_level - LONE;
              end
            end
            ST_DWELL_LO: begin
              if (r_dwell == '0) begin
                r_state <= ST_RISE;
                r_level <= r_level + LONE;
              end else begin
                r_dwell <= r_dwell - DONE;
              end
            end
            ST_DONE: r_level <= '0;
            ST_IDLE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign duty_out = r_duty;
  assign duty_upd = r_upd;
  assign at_peak  = (r_level == LMAX);
  assign at_floor = (r_level == '0);

endmodule
